// File: rtl/fetch_stage.sv
// Instruction fetch stage: selects the next fetch address and owns the IF/ID register.
// The instruction memory's output register doubles as the IF/ID instruction register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {FILL, RUN, HALT} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] count_q;
    logic        valid_q;
    logic        fault_q;

    logic        misaligned;
    logic [31:0] pc_plus4;
    logic [31:0] next_addr;

    assign misaligned = redirect_valid && (redirect_addr[1:0] != 2'b00);
    assign pc_plus4   = pc_q + 32'd4;

    // imem_addr is the pc IF/ID will hold after the next edge, so the
    // memory's registered read lines up with pc_q without an extra stage.
    always_comb begin
        next_addr = pc_plus4;
        if (rst)                  next_addr = RESET_PC;
        else if (state_q == HALT) next_addr = pc_q;
        else if (misaligned)      next_addr = pc_q;
        else if (redirect_valid)  next_addr = redirect_addr;
        else if (stall)           next_addr = pc_q;
        else if (state_q == FILL) next_addr = RESET_PC;
    end

    assign imem_addr = next_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            case (state_q)
                HALT: valid_q <= 1'b0;
                default: begin
                    if (misaligned) begin
                        fault_q <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= HALT;
                    end else if (stall && !redirect_valid) begin
                        // Stall holds everything; flush may still kill the held slot.
                        if (flush) valid_q <= 1'b0;
                    end else begin
                        pc_q    <= next_addr;
                        valid_q <= !flush;
                        state_q <= RUN;
                        if (!flush) count_q <= count_q + 32'd1;
                    end
                end
            endcase
        end
    end

    assign if_id_instr    = valid_q ? imem_rdata : 32'h0000_0000;
    assign if_id_pc       = pc_q;
    assign if_id_pc_plus4 = pc_plus4;
    assign if_id_valid    = valid_q;
    assign fetch_fault    = fault_q;
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Fetch stage bench: directed scenarios then random traffic, all checked
// against a behavioural model of the fetch rules. Memory word at address n is n.
module tb_fetch_stage;

    localparam logic [31:0] RP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count;
    logic        if_id_valid, fetch_fault;

    int n_vec = 0;
    int n_err = 0;

    // Model state: where IF/ID points, whether it is live, and lifecycle flags.
    logic [31:0] m_pc = RP;
    logic [31:0] m_count = 32'd0;
    logic        m_valid = 1'b0;
    logic        m_fault = 1'b0;
    logic        m_started = 1'b0;
    logic        m_halted = 1'b0;

    fetch_stage #(.RESET_PC(RP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
        .fetch_fault(fetch_fault), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Synchronous memory with 1-cycle read latency, contents mem[n] = n.
    always @(posedge clk) imem_rdata <= imem_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_target(input logic r, input logic s, input logic rv,
                                             input logic [31:0] ra);
        if (r) return RP;
        if (m_halted) return m_pc;
        if (rv) return (ra[1:0] != 2'b00) ? m_pc : ra;
        if (s) return m_pc;
        if (!m_started) return RP;
        return m_pc + 32'd4;
    endfunction

    task automatic step(input logic s, input logic f, input logic rv,
                        input logic [31:0] ra, input logic r);
        logic [31:0] tgt;
        @(negedge clk);
        stall = s; flush = f; redirect_valid = rv; redirect_addr = ra; rst = r;
        #1;
        tgt = m_target(r, s, rv, ra);
        chk("imem_addr", imem_addr, tgt);
        @(posedge clk);
        if (r) begin
            m_pc = RP; m_valid = 0; m_fault = 0; m_count = 0;
            m_started = 0; m_halted = 0;
        end else if (m_halted) begin
            m_valid = 0;
        end else if (rv && ra[1:0] != 2'b00) begin
            m_fault = 1; m_halted = 1; m_valid = 0;
        end else if (s && !rv) begin
            if (f) m_valid = 0;
        end else begin
            m_pc = tgt; m_valid = !f; m_started = 1;
            if (!f) m_count = m_count + 1;
        end
        #1;
        chk("valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        chk("pc", if_id_pc, m_pc);
        chk("pc_plus4", if_id_pc_plus4, m_pc + 32'd4);
        chk("instr", if_id_instr, m_valid ? m_pc : 32'd0);
        chk("fault", {31'd0, fetch_fault}, {31'd0, m_fault});
        chk("count", fetch_count, m_count);
    endtask

    initial begin
        // Free run from reset
        step(0, 0, 0, 0, 1);
        chk("rst_count", fetch_count, 32'd0);
        step(0, 0, 0, 0, 0);
        chk("fill_pc", if_id_pc, 32'h0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("run_pc8", if_id_pc, 32'h8);
        chk("run_cnt3", fetch_count, 32'd3);
        // Stall two cycles at 0x08, then release
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("stall_instr", if_id_instr, 32'h8);
        step(0, 0, 0, 0, 0);
        chk("stall_rel_pc", if_id_pc, 32'hC);
        step(0, 0, 0, 0, 0);
        // Redirect overrides stall
        step(1, 0, 1, 32'h40, 0);
        chk("redir_pc4", if_id_pc_plus4, 32'h44);
        // Flush at 0x14
        step(0, 0, 1, 32'h14, 0);
        step(0, 1, 0, 0, 0);
        chk("flush_pc", if_id_pc, 32'h18);
        chk("flush_instr", if_id_instr, 32'h0);
        step(0, 0, 0, 0, 0);
        chk("flush_next_pc", if_id_pc, 32'h1C);
        // Misaligned redirect faults; later redirect ignored; reset clears
        step(0, 0, 1, 32'h42, 0);
        chk("fault_set", {31'd0, fetch_fault}, 32'd1);
        step(0, 0, 1, 32'h80, 0);
        chk("halt_pc", if_id_pc, 32'h1C);
        step(0, 0, 0, 0, 1);
        chk("fault_clr", {31'd0, fetch_fault}, 32'd0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Reset during stall, then wrap
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'hFFFF_FFFC, 0);
        chk("wrap_pc4", if_id_pc_plus4, 32'h0);
        step(0, 0, 0, 0, 0);
        chk("wrap_pc", if_id_pc, 32'h0);

        for (int i = 0; i < 500; i++) begin
            logic s, f, rv, r;
            logic [31:0] ra;
            s  = ($urandom_range(0, 9) < 3);
            f  = ($urandom_range(0, 9) < 2);
            rv = ($urandom_range(0, 9) < 1);
            ra = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 14) == 0) ra[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFF8 | (ra & 32'h7);
            r  = m_halted ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 39) == 0);
            step(s, f, rv, ra, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
